// File: rtl/fpu_issue_ctrl.sv
// FPU issue sequencer: accepts one op at a time, times its latency with a
// down-counter, raises stall on occupancy/RAW hazards and strobes writeback.
module fpu_issue_ctrl #(
  parameter int unsigned LAT_ADD  = 3,
  parameter int unsigned LAT_MUL  = 4,
  parameter int unsigned LAT_DIV  = 12,
  parameter int unsigned LAT_SQRT = 12,
  parameter int unsigned LAT_MISC = 1,
  parameter int unsigned LAT_CVT  = 2,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       issue_valid,
  input  logic [3:0] issue_op,
  input  logic [4:0] issue_rd,
  input  logic       issue_int_dest,
  output logic       issue_ready,
  input  logic       flush,
  input  logic [4:0] chk_rs1,
  input  logic [4:0] chk_rs2,
  input  logic       chk_rs1_f,
  input  logic       chk_rs2_f,
  input  logic       chk_valid,
  output logic       fpu_start,
  output logic [3:0] fpu_op,
  output logic       stall,
  output logic       busy,
  output logic       wb_valid,
  output logic [4:0] wb_rd,
  output logic       wb_int_dest,
  output logic       wb_illegal
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       op_q;
  logic [4:0]       rd_q;
  logic             int_q;
  logic             ill_q;
  logic             start_q;

  logic [CNT_W-1:0] lat_m1;
  logic             legal;
  logic             accept;
  logic             done;
  logic             haz1;
  logic             haz2;

  always_comb begin
    lat_m1 = '0;
    case (issue_op)
      4'd0, 4'd1:       lat_m1 = CNT_W'(LAT_ADD - 1);
      4'd2:             lat_m1 = CNT_W'(LAT_MUL - 1);
      4'd3:             lat_m1 = CNT_W'(LAT_DIV - 1);
      4'd6:             lat_m1 = CNT_W'(LAT_SQRT - 1);
      4'd4, 4'd5, 4'd7: lat_m1 = CNT_W'(LAT_MISC - 1);
      4'd8, 4'd9:       lat_m1 = CNT_W'(LAT_CVT - 1);
      default:          lat_m1 = '0;
    endcase
  end

  assign legal       = (issue_op <= 4'd9);
  assign busy        = (state_q == RUN);
  assign done        = busy && (cnt_q == '0);
  assign issue_ready = (state_q == IDLE) || done;
  assign accept      = issue_valid && issue_ready && !flush;

  // Source matches only if the regfile type agrees; integer x0 is never a dependency.
  assign haz1 = (chk_rs1 == rd_q) && (chk_rs1_f ? !int_q : (int_q && (chk_rs1 != 5'd0)));
  assign haz2 = (chk_rs2 == rd_q) && (chk_rs2_f ? !int_q : (int_q && (chk_rs2 != 5'd0)));

  assign stall       = (issue_valid && !issue_ready) || (busy && chk_valid && (haz1 || haz2));
  assign wb_valid    = done && !flush;
  assign wb_rd       = rd_q;
  assign wb_int_dest = int_q;
  assign wb_illegal  = wb_valid && ill_q;
  assign fpu_start   = start_q;
  assign fpu_op      = op_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      int_q   <= 1'b0;
      ill_q   <= 1'b0;
      start_q <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else if (accept) begin
      state_q <= RUN;
      cnt_q   <= lat_m1;
      op_q    <= issue_op;
      rd_q    <= issue_rd;
      int_q   <= issue_int_dest;
      ill_q   <= !legal;
      start_q <= legal;
    end else begin
      start_q <= 1'b0;
      if (state_q == RUN) begin
        if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
        else             state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl; inputs change 1ns after the rising edge
// and outputs are checked in the same half-cycle.
module tb_fpu_issue_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       issue_valid;
  logic [3:0] issue_op;
  logic [4:0] issue_rd;
  logic       issue_int_dest;
  logic       issue_ready;
  logic       flush;
  logic [4:0] chk_rs1, chk_rs2;
  logic       chk_rs1_f, chk_rs2_f, chk_valid;
  logic       fpu_start;
  logic [3:0] fpu_op;
  logic       stall, busy, wb_valid;
  logic [4:0] wb_rd;
  logic       wb_int_dest, wb_illegal;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fpu_issue_ctrl #(
    .LAT_ADD(3), .LAT_MUL(4), .LAT_DIV(12), .LAT_SQRT(12),
    .LAT_MISC(1), .LAT_CVT(2), .CNT_W(5)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rd(issue_rd),
    .issue_int_dest(issue_int_dest), .issue_ready(issue_ready), .flush(flush),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rs1_f(chk_rs1_f), .chk_rs2_f(chk_rs2_f),
    .chk_valid(chk_valid), .fpu_start(fpu_start), .fpu_op(fpu_op), .stall(stall),
    .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_int_dest(wb_int_dest),
    .wb_illegal(wb_illegal)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_issue(input logic [3:0] op, input logic [4:0] rd, input logic idst);
    issue_valid    = 1'b1;
    issue_op       = op;
    issue_rd       = rd;
    issue_int_dest = idst;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_rd = '0; issue_int_dest = 1'b0;
    flush = 1'b0; chk_rs1 = '0; chk_rs2 = '0; chk_rs1_f = 1'b0; chk_rs2_f = 1'b0; chk_valid = 1'b0;
    step(); step();
    total++; if ({busy, wb_valid, fpu_start, stall, wb_illegal} !== 5'b0) begin bad++;
      $display("FAIL reset_outs got=%b exp=00000", {busy, wb_valid, fpu_start, stall, wb_illegal}); end
    total++; if ({fpu_op, wb_rd} !== 9'd0) begin bad++;
      $display("FAIL reset_regs got=%h exp=0", {fpu_op, wb_rd}); end
    reset_n = 1'b1;
    step();
    total++; if (issue_ready !== 1'b1) begin bad++;
      $display("FAIL reset_ready got=%b exp=1", issue_ready); end
  endtask

  task automatic test_add();
    drive_issue(4'd0, 5'd5, 1'b0);
    step();                                    // cycle T+1
    issue_valid = 1'b0; #1;
    total++; if ({fpu_start, busy, wb_valid} !== 3'b110) begin bad++;
      $display("FAIL add_t1 got=%b exp=110", {fpu_start, busy, wb_valid}); end
    total++; if (fpu_op !== 4'd0) begin bad++; $display("FAIL add_op got=%0d exp=0", fpu_op); end
    step();                                    // T+2
    total++; if ({fpu_start, busy, wb_valid} !== 3'b010) begin bad++;
      $display("FAIL add_t2 got=%b exp=010", {fpu_start, busy, wb_valid}); end
    step();                                    // T+3
    total++; if ({busy, wb_valid, wb_illegal} !== 3'b110 || wb_rd !== 5'd5 || wb_int_dest !== 1'b0) begin bad++;
      $display("FAIL add_wb got=%b rd=%0d int=%b exp=110 rd=5 int=0", {busy, wb_valid, wb_illegal}, wb_rd, wb_int_dest); end
    step();
    total++; if ({busy, wb_valid} !== 2'b00) begin bad++;
      $display("FAIL add_idle got=%b exp=00", {busy, wb_valid}); end
  endtask

  task automatic test_back_to_back();
    int stall_bad = 0;
    drive_issue(4'd3, 5'd7, 1'b0);
    step();                                    // T+1, div running
    drive_issue(4'd2, 5'd8, 1'b0); #1;
    for (int i = 0; i < 11; i++) begin         // T+1..T+11
      if (stall !== 1'b1 || issue_ready !== 1'b0 || wb_valid !== 1'b0) stall_bad++;
      step();
    end
    total++; if (stall_bad !== 0) begin bad++;
      $display("FAIL b2b_stall got=%0d bad cycles exp=0", stall_bad); end
    total++; if ({issue_ready, stall, wb_valid} !== 3'b101 || wb_rd !== 5'd7) begin bad++;
      $display("FAIL b2b_divwb got=%b rd=%0d exp=101 rd=7", {issue_ready, stall, wb_valid}, wb_rd); end
    step();                                    // T+13, mul started
    issue_valid = 1'b0; #1;
    total++; if ({fpu_start, busy, wb_valid} !== 3'b110 || fpu_op !== 4'd2) begin bad++;
      $display("FAIL b2b_mulstart got=%b op=%0d exp=110 op=2", {fpu_start, busy, wb_valid}, fpu_op); end
    step(); step(); step();                    // T+16
    total++; if ({busy, wb_valid} !== 2'b11 || wb_rd !== 5'd8) begin bad++;
      $display("FAIL b2b_mulwb got=%b rd=%0d exp=11 rd=8", {busy, wb_valid}, wb_rd); end
    step();
  endtask

  task automatic test_hazard();
    drive_issue(4'd7, 5'd10, 1'b1);
    step();                                    // compare completes in T+1
    issue_valid = 1'b0;
    chk_valid = 1'b1; chk_rs1 = 5'd10; chk_rs1_f = 1'b0; chk_rs2 = 5'd3; chk_rs2_f = 1'b0; #1;
    total++; if ({wb_valid, wb_int_dest, stall} !== 3'b111 || wb_rd !== 5'd10) begin bad++;
      $display("FAIL haz_int got=%b rd=%0d exp=111 rd=10", {wb_valid, wb_int_dest, stall}, wb_rd); end
    chk_rs1_f = 1'b1; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL haz_type got=%b exp=0", stall); end
    chk_rs2 = 5'd10; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL haz_rs2 got=%b exp=1", stall); end
    chk_valid = 1'b0; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL haz_chkoff got=%b exp=0", stall); end
    step();
    drive_issue(4'd7, 5'd0, 1'b1);
    step();
    issue_valid = 1'b0;
    chk_valid = 1'b1; chk_rs1 = 5'd0; chk_rs1_f = 1'b0; chk_rs2 = 5'd0; chk_rs2_f = 1'b0; #1;
    total++; if ({busy, stall} !== 2'b10) begin bad++;
      $display("FAIL haz_x0 got=%b exp=10", {busy, stall}); end
    chk_valid = 1'b0; chk_rs1_f = 1'b0; chk_rs2 = 5'd0;
    step();
  endtask

  task automatic test_flush();
    int wb_seen = 0;
    drive_issue(4'd6, 5'd3, 1'b0);
    step();                                    // T+1
    issue_valid = 1'b0;
    step(); step(); step(); step();            // T+5
    flush = 1'b1; #1;
    total++; if ({busy, wb_valid} !== 2'b10) begin bad++;
      $display("FAIL flush_t5 got=%b exp=10", {busy, wb_valid}); end
    step();                                    // T+6
    flush = 1'b0; #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
    for (int i = 0; i < 10; i++) begin         // T+6..T+15
      if (wb_valid !== 1'b0) wb_seen++;
      step();
    end
    total++; if (wb_seen !== 0) begin bad++; $display("FAIL flush_nowb got=%0d exp=0", wb_seen); end

    drive_issue(4'd6, 5'd3, 1'b0);
    step();                                    // T+1
    issue_valid = 1'b0;
    for (int i = 0; i < 11; i++) step();       // T+12, completion cycle
    total++; if ({busy, wb_valid} !== 2'b11) begin bad++;
      $display("FAIL flush_pre got=%b exp=11", {busy, wb_valid}); end
    flush = 1'b1; #1;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL flush_done got=%b exp=0", wb_valid); end
    step();
    flush = 1'b0; #1;
    total++; if ({busy, wb_valid, issue_ready} !== 3'b001) begin bad++;
      $display("FAIL flush_after got=%b exp=001", {busy, wb_valid, issue_ready}); end

    drive_issue(4'd0, 5'd1, 1'b0);
    flush = 1'b1;
    step();
    issue_valid = 1'b0; flush = 1'b0; #1;
    total++; if ({busy, fpu_start} !== 2'b00) begin bad++;
      $display("FAIL flush_idle got=%b exp=00", {busy, fpu_start}); end
  endtask

  task automatic test_illegal();
    drive_issue(4'd12, 5'd4, 1'b0);
    step();                                    // T+1
    issue_valid = 1'b0; #1;
    total++; if ({fpu_start, wb_valid, wb_illegal} !== 3'b011 || wb_rd !== 5'd4) begin bad++;
      $display("FAIL illegal got=%b rd=%0d exp=011 rd=4", {fpu_start, wb_valid, wb_illegal}, wb_rd); end
    step();
    total++; if ({busy, wb_valid} !== 2'b00) begin bad++;
      $display("FAIL illegal_idle got=%b exp=00", {busy, wb_valid}); end
  endtask

  task automatic test_reset_midop();
    int wb_seen = 0;
    drive_issue(4'd2, 5'd9, 1'b0);
    step();                                    // T+1
    issue_valid = 1'b0;
    step();                                    // T+2
    reset_n = 1'b0; #1;
    total++; if ({busy, wb_valid, fpu_start, stall} !== 4'b0 || fpu_op !== 4'd0 || wb_rd !== 5'd0) begin bad++;
      $display("FAIL rst_mid got=%b op=%0d rd=%0d exp=0000 op=0 rd=0", {busy, wb_valid, fpu_start, stall}, fpu_op, wb_rd); end
    step(); step();
    reset_n = 1'b1; #1;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", issue_ready); end
    for (int i = 0; i < 6; i++) begin
      if (wb_valid !== 1'b0 || busy !== 1'b0) wb_seen++;
      step();
    end
    total++; if (wb_seen !== 0) begin bad++; $display("FAIL rst_nowb got=%0d exp=0", wb_seen); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_hazard();
    test_flush();
    test_illegal();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
